alu_seq: RTL and testbench

- Parametrised, handshaked successor to the 32-bit combinational ALU core.
- Retains the full ALU opcode set: ADD, SUB, AND, OR, XOR, NOT(=NOR), SLL, SRL, SRA, SLT, SLTU.
- Adds iterative unsigned multiply and divide (MUL, MULHU, DIVU, REMU).
- Sits between the register-read stage and writeback. Uses valid/ready on both sides, so the pipeline can stall on multi-cycle ops.

---
 rtl/alu_seq_pkg.sv | 46 ++++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_muldiv_iter.sv | 87 ++++++++
 rtl/alu_seq.sv | 134 +++++++++++++
 tb/tb_alu_seq.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode codes, FSM states and flag positions for the sequential ALU.
// Opcode values 0..A match the original combinational core; B..E add mul/div.
package alu_seq_pkg;

  localparam logic [3:0] ALU_OP_ADD   = 4'h0;
  localparam logic [3:0] ALU_OP_SUB   = 4'h1;
  localparam logic [3:0] ALU_OP_AND   = 4'h2;
  localparam logic [3:0] ALU_OP_OR    = 4'h3;
  localparam logic [3:0] ALU_OP_XOR   = 4'h4;
  localparam logic [3:0] ALU_OP_NOT   = 4'h5;
  localparam logic [3:0] ALU_OP_SLL   = 4'h6;
  localparam logic [3:0] ALU_OP_SRL   = 4'h7;
  localparam logic [3:0] ALU_OP_SRA   = 4'h8;
  localparam logic [3:0] ALU_OP_SLT   = 4'h9;
  localparam logic [3:0] ALU_OP_SLTU  = 4'hA;
  localparam logic [3:0] ALU_OP_MUL   = 4'hB;
  localparam logic [3:0] ALU_OP_MULHU = 4'hC;
  localparam logic [3:0] ALU_OP_DIVU  = 4'hD;
  localparam logic [3:0] ALU_OP_REMU  = 4'hE;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_MULHU) ||
           (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
  endfunction

  // MULHU and REMU take the upper half of the iterator's {hi, lo} pair.
  function automatic logic is_hi_op(input logic [3:0] op);
    return (op == ALU_OP_MULHU) || (op == ALU_OP_REMU);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bundle. Handshake rule: a transfer happens on a rising edge
// where valid and ready are both 1; a source holds its payload until then.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic [3:0]       FLAGS;
  logic             div_by_zero;

  modport master (
    output in_valid, A, B, alu_op, out_ready,
    input  in_ready, out_valid, Y, FLAGS, div_by_zero
  );

  modport slave (
    input  in_valid, A, B, alu_op, out_ready,
    output in_ready, out_valid, Y, FLAGS, div_by_zero
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// lo/hi present the result of the current step; they are final when done=1.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] step_lo, step_hi;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    if (div_q) begin
      // Difference always fits in WIDTH bits when the subtraction is taken.
      step_hi = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    done = busy_q && (cnt_q == LAST);
    lo   = step_lo;
    hi   = step_hi;
  end

  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    b_d    = b_q;
    if (start) begin
      busy_d = 1'b1;
      div_d  = is_div;
      cnt_d  = '0;
      lo_d   = A;
      hi_d   = '0;
      b_d    = B;
    end else if (busy_q) begin
      lo_d  = step_lo;
      hi_d  = step_hi;
      cnt_d = cnt_q + 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      b_q    <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      b_q    <= b_d;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops finish on accept, mul/div run WIDTH cycles
// in BUSY, and the registered result is held in DONE until consumed.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_if.slave       bus,
  output state_t         dbg_state
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       flags_q, flags_d;
  logic             dbz_q, dbz_d;

  logic             start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo, iter_hi, iter_res;

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c, alu_v;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_div (is_div_op(bus.alu_op)),
    .A      (bus.A),
    .B      (bus.B),
    .done   (iter_done),
    .lo     (iter_lo),
    .hi     (iter_hi)
  );

  // Single-cycle datapath; unknown opcodes fall through to ADD.
  always_comb begin
    sub     = (bus.alu_op == ALU_OP_SUB);
    b_eff   = sub ? ~bus.B : bus.B;
    add_sum = {1'b0, bus.A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    shamt   = bus.B[SHW-1:0];
    alu_y   = add_sum[WIDTH-1:0];
    alu_c   = add_sum[WIDTH];
    alu_v   = (bus.A[WIDTH-1] == b_eff[WIDTH-1]) &&
              (add_sum[WIDTH-1] != bus.A[WIDTH-1]);
    if (!(sub || bus.alu_op == ALU_OP_ADD) && !(bus.alu_op > ALU_OP_SLTU)) begin
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (bus.alu_op)
        ALU_OP_AND:  alu_y = bus.A & bus.B;
        ALU_OP_OR:   alu_y = bus.A | bus.B;
        ALU_OP_XOR:  alu_y = bus.A ^ bus.B;
        ALU_OP_NOT:  alu_y = ~(bus.A | bus.B);
        ALU_OP_SLL:  alu_y = bus.A << shamt;
        ALU_OP_SRL:  alu_y = bus.A >> shamt;
        ALU_OP_SRA:  alu_y = $unsigned($signed(bus.A) >>> shamt);
        ALU_OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
        ALU_OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
        default:     alu_y = add_sum[WIDTH-1:0];
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    y_d          = y_q;
    flags_d      = flags_q;
    dbz_d        = dbz_q;
    start        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    iter_res     = is_hi_op(op_q) ? iter_hi : iter_lo;
    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          op_d = bus.alu_op;
          if (is_iter_op(bus.alu_op)) begin
            start   = 1'b1;
            dbz_d   = is_div_op(bus.alu_op) && (bus.B == '0);
            state_d = ST_BUSY;
          end else begin
            y_d     = alu_y;
            flags_d = {alu_y[WIDTH-1], alu_y == '0, alu_c, alu_v};
            dbz_d   = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (iter_done) begin
          y_d     = iter_res;
          flags_d = {iter_res[WIDTH-1], iter_res == '0, 2'b00};
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= ALU_OP_ADD;
      y_q     <= '0;
      flags_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      y_q     <= y_d;
      flags_q <= flags_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.Y           = y_q;
  assign bus.FLAGS       = flags_q;
  assign bus.div_by_zero = dbz_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 plus a WIDTH=8 instance for the
// narrow multiply/divide regression.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t st32, st8;
  int     checks = 0;
  int     errors = 0;
  int     lat;

  alu_seq_if #(.WIDTH(32)) bus32 ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32), .dbg_state(st32));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8),  .dbg_state(st8));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op on the 32-bit port and wait (bounded) for out_valid.
  task automatic op32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int latency);
    bus32.alu_op   = op;
    bus32.A        = a;
    bus32.B        = b;
    bus32.in_valid = 1'b1;
    tick();
    bus32.in_valid = 1'b0;
    latency = 1;
    while (!bus32.out_valid && latency < 100) begin
      tick();
      latency++;
    end
  endtask

  task automatic op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     output int latency);
    bus8.alu_op   = op;
    bus8.A        = a;
    bus8.B        = b;
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    latency = 1;
    while (!bus8.out_valid && latency < 100) begin
      tick();
      latency++;
    end
  endtask

  task automatic consume32();
    bus32.out_ready = 1'b1;
    tick();
    bus32.out_ready = 1'b0;
  endtask

  task automatic consume8();
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
  endtask

  task automatic res32(input string tag, input int latency, input int exp_lat,
                       input logic [31:0] y, input logic [3:0] fl, input logic dbz);
    check({tag, "_lat"},   64'(latency),        64'(exp_lat));
    check({tag, "_y"},     64'(bus32.Y),        64'(y));
    check({tag, "_flags"}, 64'(bus32.FLAGS),    64'(fl));
    check({tag, "_dbz"},   64'(bus32.div_by_zero), 64'(dbz));
    consume32();
  endtask

  initial begin
    rst = 1'b1;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
    bus32.A = '0; bus32.B = '0; bus32.alu_op = '0;
    bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;
    bus8.A = '0;  bus8.B = '0;  bus8.alu_op = '0;
    tick();
    tick();
    check("rst_in_ready",  64'(bus32.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst_y",         64'(bus32.Y),         64'd0);
    check("rst_flags",     64'(bus32.FLAGS),     64'd0);
    check("rst_state",     64'(st32),            64'(ST_IDLE));
    rst = 1'b0;
    tick();

    op32(ALU_OP_ADD,  32'h7FFF_FFFF, 32'd1, lat);        res32("add_ovf",  lat, 1, 32'h8000_0000, 4'b1001, 1'b0);
    op32(ALU_OP_SUB,  32'd5, 32'd5, lat);                res32("sub_eq",   lat, 1, 32'h0,         4'b0110, 1'b0);
    op32(ALU_OP_SUB,  32'd0, 32'd1, lat);                res32("sub_brw",  lat, 1, 32'hFFFF_FFFF, 4'b1000, 1'b0);
    op32(ALU_OP_SRA,  32'h8000_0000, 32'd31, lat);       res32("sra",      lat, 1, 32'hFFFF_FFFF, 4'b1000, 1'b0);
    op32(ALU_OP_SLL,  32'h1234_5678, 32'h20, lat);       res32("sll_0",    lat, 1, 32'h1234_5678, 4'b0000, 1'b0);
    op32(ALU_OP_SRL,  32'h8000_0000, 32'd4, lat);        res32("srl",      lat, 1, 32'h0800_0000, 4'b0000, 1'b0);
    op32(ALU_OP_NOT,  32'h0F0F_0F0F, 32'h00FF_0000, lat); res32("nor",     lat, 1, 32'hF000_F0F0, 4'b1000, 1'b0);
    op32(ALU_OP_AND,  32'hF0, 32'h3C, lat);              res32("and",      lat, 1, 32'h30,        4'b0000, 1'b0);
    op32(ALU_OP_XOR,  32'hFF, 32'h0F, lat);              res32("xor",      lat, 1, 32'hF0,        4'b0000, 1'b0);
    op32(ALU_OP_SLT,  32'hFFFF_FFFF, 32'd1, lat);        res32("slt",      lat, 1, 32'h1,         4'b0000, 1'b0);
    op32(ALU_OP_SLTU, 32'hFFFF_FFFF, 32'd1, lat);        res32("sltu",     lat, 1, 32'h0,         4'b0100, 1'b0);
    op32(4'hF,        32'd1, 32'd2, lat);                res32("unk_add",  lat, 1, 32'h3,         4'b0000, 1'b0);

    op32(ALU_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat); res32("mulhu", lat, 33, 32'hFFFF_FFFE, 4'b1000, 1'b0);
    op32(ALU_OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, lat); res32("mul",   lat, 33, 32'h1,         4'b0000, 1'b0);
    op32(ALU_OP_DIVU,  32'd100, 32'd0, lat);             res32("divu_z",   lat, 33, 32'hFFFF_FFFF, 4'b1000, 1'b1);
    op32(ALU_OP_REMU,  32'd100, 32'd0, lat);             res32("remu_z",   lat, 33, 32'd100,      4'b0000, 1'b1);
    op32(ALU_OP_DIVU,  32'd100, 32'd7, lat);             res32("divu",     lat, 33, 32'd14,       4'b0000, 1'b0);
    op32(ALU_OP_REMU,  32'd100, 32'd7, lat);             res32("remu",     lat, 33, 32'd2,        4'b0000, 1'b0);

    // Hold in DONE with out_ready low while another op is offered.
    op32(ALU_OP_ADD, 32'd3, 32'd4, lat);
    bus32.alu_op = ALU_OP_SUB; bus32.A = 32'd9; bus32.B = 32'd1; bus32.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_y",     64'(bus32.Y),         64'd7);
      check("hold_flags", 64'(bus32.FLAGS),     64'd0);
      check("hold_ready", 64'(bus32.in_ready),  64'd0);
      check("hold_valid", 64'(bus32.out_valid), 64'd1);
      tick();
    end
    bus32.in_valid = 1'b0;
    check("hold_end_y", 64'(bus32.Y), 64'd7);

    // Reset at BUSY cycle 10 abandons the multiply.
    consume32();
    bus32.alu_op = ALU_OP_MUL; bus32.A = 32'd3; bus32.B = 32'd5; bus32.in_valid = 1'b1;
    tick();
    bus32.in_valid = 1'b0;
    check("busy_state", 64'(st32), 64'(ST_BUSY));
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rbusy_valid", 64'(bus32.out_valid), 64'd0);
    check("rbusy_ready", 64'(bus32.in_ready),  64'd1);
    check("rbusy_y",     64'(bus32.Y),         64'd0);
    check("rbusy_state", 64'(st32),            64'(ST_IDLE));
    op32(ALU_OP_MUL, 32'd3, 32'd5, lat);                 res32("mul_after", lat, 33, 32'd15, 4'b0000, 1'b0);

    // Reset coinciding with in_valid accepts nothing.
    bus32.alu_op = ALU_OP_ADD; bus32.A = 32'd1; bus32.B = 32'd1; bus32.in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus32.in_valid = 1'b0;
    tick();
    check("rst_win_valid", 64'(bus32.out_valid), 64'd0);
    check("rst_win_state", 64'(st32),            64'(ST_IDLE));

    // Narrow instance regression.
    op8(ALU_OP_MUL, 8'hFF, 8'hFF, lat);
    check("w8_mul_lat", 64'(lat), 64'd9);
    check("w8_mul_y",   64'(bus8.Y), 64'h01);
    consume8();
    op8(ALU_OP_MULHU, 8'hFF, 8'hFF, lat);
    check("w8_mulhu_y",     64'(bus8.Y),     64'hFE);
    check("w8_mulhu_flags", 64'(bus8.FLAGS), 64'b1000);
    consume8();
    op8(ALU_OP_DIVU, 8'd200, 8'd3, lat);
    check("w8_divu_y", 64'(bus8.Y), 64'd66);
    consume8();
    op8(ALU_OP_REMU, 8'd200, 8'd3, lat);
    check("w8_remu_y", 64'(bus8.Y), 64'd2);
    consume8();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
